setpoint_cfg: RTL and testbench
===============================

# setpoint_cfg

Parametrised command-configuration block for the quadcopter: the generalised successor to the fixed pitch/roll/yaw/thrust command decoder. It sits between `UART_comm` (source of `cmd`/`data`/`cmd_rdy`, sink of `resp`/`send_resp`) and the flight controller/inertial integrator. It decodes each remote command into per-axis setpoints, thrust, and calibration and motor control. Relative to the current decoder it adds:
- N axes with configurable width, and saturating conversion;
- negative acknowledge for illegal opcodes;
- a command watchdog that forces emergency landing.

## Interface
- `NUM_AXES`, 3: number of attitude axes (1..8); axis 0/1/2 = pitch/roll/yaw.
- `AXIS_W`, 16: signed setpoint width per axis (8..24).
- `THRST_W`, 9: unsigned thrust width (1..16).
- `RAMP_W`, 26: motor spin-up timer width; the ramp lasts 2^RAMP_W−1 cycles.
- `WDOG_W`, 28: watchdog width; it expires after 2^WDOG_W−1 idle cycles.
- `WDOG_EN`, 1: 0 removes the watchdog entirely.
- `clk` in 1: system clock; single clock domain, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_rdy` in 1: a command/data pair is valid on `cmd`/`data`.
- `cmd` in 8: opcode.
- `data` in 16: command payload.
- `cal_done` in 1: one-cycle pulse from the integrator when gyro calibration finishes.
- `clr_cmd_rdy` out 1: consumes the current command.
- `send_resp` out 1: one-cycle pulse; `resp` must be valid in the same cycle.
- `resp` out 8: 8'hA5 positive ack, 8'hEE negative ack.
- `d_axis` out NUM_AXES*AXIS_W: packed signed setpoints; axis k occupies bits [k*AXIS_W +: AXIS_W].
- `thrst` out THRST_W: thrust setpoint.
- `strt_cal` out 1: one-cycle pulse that starts gyro calibration.
- `inertial_cal` out 1: high from CAL acceptance through `cal_done`.
- `motors_off` out 1: motors disabled.
- `wdog_trip` out 1: sticky flag; the watchdog forced a landing.

## Operation
- FSM states: IDLE, ACK, RAMP, CAL.
- IDLE with `cmd_rdy`=1 decodes `cmd`. All decoded actions register at the end of that cycle. Opcodes:
  - 0x02/0x03/0x04 are legacy aliases for axis 0/1/2. An alias is legal only if its index is < NUM_AXES.
  - 0x10+k (k<NUM_AXES) sets axis k.
  - 0x05 SET_THRST.
  - 0x06 CAL.
  - 0x07 EMER_LAND: all axes and thrust go to 0.
  - 0x08 MTRS_OFF: `motors_off`=1.
  - Any other opcode → NACK (8'hEE); no state changes.
- Axis conversion takes `data` as signed 16-bit:
  - AXIS_W≥16: sign-extend.
  - AXIS_W<16: saturate to [−2^(AXIS_W−1), 2^(AXIS_W−1)−1].
- Thrust conversion takes `data` as unsigned; values above 2^THRST_W−1 saturate to 2^THRST_W−1.
- Every non-CAL command → ACK state for one cycle. In that cycle `clr_cmd_rdy`=1, `send_resp`=1, and `resp` carries A5 or EE. The FSM then returns to IDLE.
- CAL sequence:
  - On acceptance: `clr_cmd_rdy` pulses and `motors_off`←0, `inertial_cal`←1, ramp timer cleared → RAMP.
  - RAMP → CAL when the timer reaches all-ones; `strt_cal` pulses that cycle.
  - In CAL, `cal_done` → `inertial_cal`←0, `send_resp` with A5 → IDLE.
- `cmd_rdy` arriving during RAMP/CAL is not consumed. It is held and decoded on the first IDLE cycle.
- Watchdog (WDOG_EN=1):
  - The counter clears on every accepted command and while `motors_off`=1 or the FSM is not IDLE; otherwise it increments.
  - On reaching all-ones in IDLE with no `cmd_rdy`: all setpoints go to 0, `wdog_trip`←1, counter clears. There is no response.
  - `cmd_rdy` in the same cycle as expiry: the command wins and the watchdog does not fire.
  - `wdog_trip` clears on the next accepted legal command.
- Reset values:
  - All setpoints, `thrst`, `strt_cal`, `inertial_cal`, `send_resp`, `clr_cmd_rdy` and `wdog_trip` = 0; `resp`=8'h00; `motors_off`=1.
  - State = IDLE, timers = 0.
  - Reset mid-RAMP/CAL aborts the sequence and sends no response.

## Timing
- Command decoded in cycle N → outputs updated, `clr_cmd_rdy`/`send_resp` high in N+1 (ACK) → IDLE in N+2. `cmd_rdy` must be low by N+2, which `UART_comm` guarantees.
- CAL accepted in N:
  - `inertial_cal`=1 and `motors_off`=0 in N+1.
  - `strt_cal` pulses in cycle N+2^RAMP_W.
  - `cal_done` in cycle M → `send_resp` and `inertial_cal`=0 in M+1.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `setpoint_cfg_pkg`: opcode constants (SET_AXIS_BASE=8'h10, legacy 0x02–0x04, 0x05–0x08), POS_ACK=8'hA5, NEG_ACK=8'hEE, FSM state enum.
- Sub-module `cmd_wdog` (parameter WDOG_W): clear/enable inputs, expire pulse output. It is generated only when WDOG_EN=1.

## Test plan
- NUM_AXES=3, AXIS_W=16: send 0x02/0x5632, 0x03/0x3214, 0x04/0x7877 → axes equal those values; each gets one `send_resp` with A5 and exactly one `clr_cmd_rdy` cycle.
- AXIS_W=12: 0x10/0x7FFF → 12'h7FF; 0x11/0x8000 → 12'h800. THRST_W=9: 0x05/0x0343 → 9'h1FF.
- RAMP_W=4: CAL → `inertial_cal`=1 next cycle, `strt_cal` exactly 16 cycles after acceptance; `cal_done` → A5 one cycle later. A SET_THRST issued during RAMP executes only after return to IDLE.
- Illegal opcode 0x09, and 0x10+3 with NUM_AXES=3 → EE; setpoints unchanged.
- WDOG_W=6: after CAL and setpoints, idle 63 cycles → all setpoints 0, `wdog_trip`=1. Repeat with `cmd_rdy` on the expiry cycle → command executes, no trip.
- Assert `rst` mid-RAMP → all reset values next cycle, `motors_off`=1, no `strt_cal`.

Source files
------------

// File: rtl/setpoint_cfg_pkg.sv
// Shared opcodes, response codes and FSM encoding for the setpoint
// configuration block and its watchdog.
package setpoint_cfg_pkg;

  localparam logic [7:0] OP_SET_PTCH   = 8'h02;
  localparam logic [7:0] OP_SET_ROLL   = 8'h03;
  localparam logic [7:0] OP_SET_YAW    = 8'h04;
  localparam logic [7:0] OP_SET_THRST  = 8'h05;
  localparam logic [7:0] OP_CAL        = 8'h06;
  localparam logic [7:0] OP_EMER_LAND  = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF   = 8'h08;
  localparam logic [7:0] SET_AXIS_BASE = 8'h10;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

  // legacy aliases 0x02..0x04 map onto axes 0..2
  localparam int NUM_LEGACY = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACK  = 2'd1;
  localparam state_t ST_RAMP = 2'd2;
  localparam state_t ST_CAL  = 2'd3;

  function automatic logic [7:0] axis_op(input int k);
    return SET_AXIS_BASE + 8'(k);
  endfunction

  function automatic logic [7:0] legacy_op(input int k);
    return OP_SET_PTCH + 8'(k);
  endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Idle-command watchdog: counts enabled cycles, flags expiry when the
// counter sits at all-ones. Clear has priority over enable.
module cmd_wdog #(
  parameter int WDOG_W = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = &cnt_q;

endmodule

// File: rtl/setpoint_cfg.sv
// Remote-command decoder: per-axis setpoints, thrust, calibration sequencing,
// ACK/NACK responses and an optional idle watchdog forcing a landing.
module setpoint_cfg
  import setpoint_cfg_pkg::*;
#(
  parameter int NUM_AXES = 3,
  parameter int AXIS_W   = 16,
  parameter int THRST_W  = 9,
  parameter int RAMP_W   = 26,
  parameter int WDOG_W   = 28,
  parameter bit WDOG_EN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_rdy,
  input  logic [7:0]                   cmd,
  input  logic [15:0]                  data,
  input  logic                         cal_done,
  output logic                         clr_cmd_rdy,
  output logic                         send_resp,
  output logic [7:0]                   resp,
  output logic [NUM_AXES*AXIS_W-1:0]   d_axis,
  output logic [THRST_W-1:0]           thrst,
  output logic                         strt_cal,
  output logic                         inertial_cal,
  output logic                         motors_off,
  output logic                         wdog_trip
);

  localparam logic [RAMP_W-1:0] RAMP_LAST = ~RAMP_W'(1);
  localparam logic [15:0]       THR_MAX   = 16'((1 << THRST_W) - 1);

  state_t                             state_q, state_d;
  logic [RAMP_W-1:0]                  ramp_q, ramp_d;
  logic [NUM_AXES-1:0][AXIS_W-1:0]    axis_q, axis_d;
  logic [THRST_W-1:0]                 thrst_q, thrst_d;
  logic [7:0]                         resp_q, resp_d;
  logic strt_cal_q, strt_cal_d, inertial_cal_q, inertial_cal_d;
  logic send_resp_q, send_resp_d, clr_cmd_rdy_q, clr_cmd_rdy_d;
  logic motors_off_q, motors_off_d, wdog_trip_q, wdog_trip_d;

  logic [NUM_AXES-1:0] axis_hit;
  logic                legal, idle, accept;
  logic [AXIS_W-1:0]   axis_val;
  logic [THRST_W-1:0]  thrst_val;
  logic signed [15:0]  data_s;
  logic                wdog_exp, wdog_fire, wdog_clr, wdog_en;

  assign data_s = data;

  always_comb begin
    for (int k = 0; k < NUM_AXES; k++)
      axis_hit[k] = (cmd == axis_op(k)) || (k < NUM_LEGACY && cmd == legacy_op(k));
  end

  assign legal = (|axis_hit) ||
                 (cmd inside {OP_SET_THRST, OP_CAL, OP_EMER_LAND, OP_MTRS_OFF});

  generate
    if (AXIS_W >= 16) begin : g_axis_ext
      assign axis_val = AXIS_W'(data_s);
    end else begin : g_axis_sat
      localparam logic signed [15:0] AX_MAX = 16'((1 << (AXIS_W - 1)) - 1);
      localparam logic signed [15:0] AX_MIN = -AX_MAX - 16'sd1;
      always_comb begin
        if (data_s > AX_MAX)      axis_val = AX_MAX[AXIS_W-1:0];
        else if (data_s < AX_MIN) axis_val = AX_MIN[AXIS_W-1:0];
        else                      axis_val = data_s[AXIS_W-1:0];
      end
    end
  endgenerate

  assign thrst_val = (data > THR_MAX) ? THR_MAX[THRST_W-1:0] : data[THRST_W-1:0];

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle & cmd_rdy;
  // a command arriving on the expiry cycle pre-empts the landing
  assign wdog_fire = wdog_exp & idle & ~cmd_rdy & ~motors_off_q;
  assign wdog_clr  = accept | motors_off_q | ~idle | wdog_fire;
  assign wdog_en   = idle & ~motors_off_q;

  generate
    if (WDOG_EN) begin : g_wdog
      cmd_wdog #(.WDOG_W(WDOG_W)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (wdog_exp)
      );
    end else begin : g_no_wdog
      logic unused_wdog;
      assign unused_wdog = wdog_clr ^ wdog_en;
      assign wdog_exp    = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    ramp_d         = ramp_q;
    axis_d         = axis_q;
    thrst_d        = thrst_q;
    resp_d         = resp_q;
    strt_cal_d     = 1'b0;
    send_resp_d    = 1'b0;
    clr_cmd_rdy_d  = 1'b0;
    inertial_cal_d = inertial_cal_q;
    motors_off_d   = motors_off_q;
    wdog_trip_d    = wdog_trip_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          clr_cmd_rdy_d = 1'b1;
          if (cmd == OP_CAL) begin
            motors_off_d   = 1'b0;
            inertial_cal_d = 1'b1;
            ramp_d         = '0;
            wdog_trip_d    = 1'b0;
            state_d        = ST_RAMP;
          end else begin
            send_resp_d = 1'b1;
            resp_d      = legal ? POS_ACK : NEG_ACK;
            state_d     = ST_ACK;
            if (legal) begin
              wdog_trip_d = 1'b0;
              for (int k = 0; k < NUM_AXES; k++)
                if (axis_hit[k]) axis_d[k] = axis_val;
              case (cmd)
                OP_SET_THRST: thrst_d = thrst_val;
                OP_EMER_LAND: begin
                  axis_d  = '0;
                  thrst_d = '0;
                end
                OP_MTRS_OFF:  motors_off_d = 1'b1;
                default: ;
              endcase
            end
          end
        end else if (wdog_fire) begin
          axis_d      = '0;
          thrst_d     = '0;
          wdog_trip_d = 1'b1;
        end
      end
      ST_ACK: state_d = ST_IDLE;
      ST_RAMP: begin
        ramp_d = ramp_q + RAMP_W'(1);
        // registered strt_cal lands on the cycle the timer reads all-ones
        if (ramp_q == RAMP_LAST) begin
          strt_cal_d = 1'b1;
          state_d    = ST_CAL;
        end
      end
      ST_CAL: begin
        if (cal_done) begin
          inertial_cal_d = 1'b0;
          send_resp_d    = 1'b1;
          resp_d         = POS_ACK;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ramp_q         <= '0;
      axis_q         <= '0;
      thrst_q        <= '0;
      resp_q         <= 8'h00;
      strt_cal_q     <= 1'b0;
      send_resp_q    <= 1'b0;
      clr_cmd_rdy_q  <= 1'b0;
      inertial_cal_q <= 1'b0;
      motors_off_q   <= 1'b1;
      wdog_trip_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ramp_q         <= ramp_d;
      axis_q         <= axis_d;
      thrst_q        <= thrst_d;
      resp_q         <= resp_d;
      strt_cal_q     <= strt_cal_d;
      send_resp_q    <= send_resp_d;
      clr_cmd_rdy_q  <= clr_cmd_rdy_d;
      inertial_cal_q <= inertial_cal_d;
      motors_off_q   <= motors_off_d;
      wdog_trip_q    <= wdog_trip_d;
    end
  end

  assign d_axis       = axis_q;
  assign thrst        = thrst_q;
  assign resp         = resp_q;
  assign strt_cal     = strt_cal_q;
  assign send_resp    = send_resp_q;
  assign clr_cmd_rdy  = clr_cmd_rdy_q;
  assign inertial_cal = inertial_cal_q;
  assign motors_off   = motors_off_q;
  assign wdog_trip    = wdog_trip_q;

endmodule

// File: tb/tb_setpoint_cfg.sv
// Directed bench: narrow-axis DUT with short ramp/watchdog, plus a wide-axis
// single-axis DUT without watchdog for sign extension and alias legality.
module tb_setpoint_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_rdy = 1'b0, cal_done = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, wdog_trip;
  logic [7:0]  resp;
  logic [35:0] d_axis;
  logic [8:0]  thrst;

  logic        cmd_rdy2 = 1'b0, cal_done2 = 1'b0;
  logic [7:0]  cmd2 = 8'h00;
  logic [15:0] data2 = 16'h0000;
  logic        clr2, send2, strt2, ical2, moff2, trip2;
  logic [7:0]  resp2;
  logic [19:0] d_axis2;
  logic [15:0] thrst2;

  int total = 0;
  int bad   = 0;

  setpoint_cfg #(.NUM_AXES(3), .AXIS_W(12), .THRST_W(9), .RAMP_W(4),
                 .WDOG_W(6), .WDOG_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .d_axis(d_axis), .thrst(thrst), .strt_cal(strt_cal),
    .inertial_cal(inertial_cal), .motors_off(motors_off), .wdog_trip(wdog_trip)
  );

  setpoint_cfg #(.NUM_AXES(1), .AXIS_W(20), .THRST_W(16), .RAMP_W(2),
                 .WDOG_W(4), .WDOG_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy2), .cmd(cmd2), .data(data2),
    .cal_done(cal_done2), .clr_cmd_rdy(clr2), .send_resp(send2),
    .resp(resp2), .d_axis(d_axis2), .thrst(thrst2), .strt_cal(strt2),
    .inertial_cal(ical2), .motors_off(moff2), .wdog_trip(trip2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a command for one cycle; returns one cycle after acceptance
  task automatic drive(input logic [7:0] op, input logic [15:0] d);
    cmd = op; data = d; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
  endtask

  task automatic drive2(input logic [7:0] op, input logic [15:0] d);
    cmd2 = op; data2 = d; cmd_rdy2 = 1'b1;
    tick();
    cmd_rdy2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({d_axis, thrst} !== 45'h0) begin bad++; $display("FAIL reset_setpoints got=%h exp=0", {d_axis, thrst}); end
    total++;
    if ({motors_off, strt_cal, inertial_cal, send_resp, clr_cmd_rdy, wdog_trip} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags got=%b exp=100000",
                      {motors_off, strt_cal, inertial_cal, send_resp, clr_cmd_rdy, wdog_trip});
    end
    total++;
    if (resp !== 8'h00) begin bad++; $display("FAIL reset_resp got=%h exp=00", resp); end
    total++;
    if ({d_axis2, moff2} !== 21'h1) begin bad++; $display("FAIL reset_dut2 got=%h exp=1", {d_axis2, moff2}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wide();
    drive2(8'h10, 16'h8001);
    total++;
    if ({resp2, d_axis2} !== {8'hA5, 20'hF8001}) begin bad++; $display("FAIL wide_sext got=%h exp=a5f8001", {resp2, d_axis2}); end
    tick();
    drive2(8'h02, 16'h1234); tick();
    total++;
    if (d_axis2 !== 20'h01234) begin bad++; $display("FAIL wide_legacy got=%h exp=01234", d_axis2); end
    drive2(8'h03, 16'h0000);
    total++;
    if ({send2, resp2} !== {1'b1, 8'hEE}) begin bad++; $display("FAIL wide_alias_nack got=%h exp=1ee", {send2, resp2}); end
    tick();
    drive2(8'h11, 16'h0777);
    total++;
    if (resp2 !== 8'hEE) begin bad++; $display("FAIL wide_axis1_nack got=%h exp=ee", resp2); end
    tick();
    total++;
    if (d_axis2 !== 20'h01234) begin bad++; $display("FAIL wide_unchanged got=%h exp=01234", d_axis2); end
    drive2(8'h05, 16'hFFFF); tick();
    total++;
    if (thrst2 !== 16'hFFFF) begin bad++; $display("FAIL wide_thrst got=%h exp=ffff", thrst2); end
  endtask

  task automatic test_legacy();
    drive(8'h02, 16'h0123);
    total++;
    if ({clr_cmd_rdy, send_resp, resp} !== {2'b11, 8'hA5}) begin
      bad++; $display("FAIL legacy_ack got=%h exp=3a5", {clr_cmd_rdy, send_resp, resp});
    end
    total++;
    if (d_axis[11:0] !== 12'h123) begin bad++; $display("FAIL legacy_axis0 got=%h exp=123", d_axis[11:0]); end
    tick();
    total++;
    if ({clr_cmd_rdy, send_resp} !== 2'b00) begin bad++; $display("FAIL legacy_single_pulse got=%b exp=00", {clr_cmd_rdy, send_resp}); end
    drive(8'h03, 16'hFF80); tick();
    drive(8'h04, 16'h7877);
    total++;
    if ({send_resp, resp} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL legacy_yaw_ack got=%h exp=1a5", {send_resp, resp}); end
    tick();
    total++;
    if (d_axis !== {12'h7FF, 12'hF80, 12'h123}) begin bad++; $display("FAIL legacy_axes got=%h exp=7fff80123", d_axis); end
  endtask

  task automatic test_saturation();
    drive(8'h10, 16'h7FFF); tick();
    drive(8'h11, 16'h8000); tick();
    drive(8'h12, 16'hF801); tick();
    total++;
    if (d_axis !== {12'h801, 12'h800, 12'h7FF}) begin bad++; $display("FAIL sat_axes got=%h exp=8018007ff", d_axis); end
    drive(8'h05, 16'h0343);
    total++;
    if (thrst !== 9'h1FF) begin bad++; $display("FAIL sat_thrst_hi got=%h exp=1ff", thrst); end
    tick();
    drive(8'h05, 16'h0042); tick();
    total++;
    if (thrst !== 9'h042) begin bad++; $display("FAIL thrst_pass got=%h exp=042", thrst); end
    drive(8'h05, 16'h0200); tick();
    total++;
    if (thrst !== 9'h1FF) begin bad++; $display("FAIL sat_thrst_edge got=%h exp=1ff", thrst); end
    drive(8'h05, 16'h01FE); tick();
    total++;
    if (thrst !== 9'h1FE) begin bad++; $display("FAIL thrst_max_minus1 got=%h exp=1fe", thrst); end
  endtask

  task automatic test_nack();
    drive(8'h09, 16'h1234);
    total++;
    if ({clr_cmd_rdy, send_resp, resp} !== {2'b11, 8'hEE}) begin
      bad++; $display("FAIL nack_09 got=%h exp=3ee", {clr_cmd_rdy, send_resp, resp});
    end
    tick();
    drive(8'h13, 16'h0555);
    total++;
    if (resp !== 8'hEE) begin bad++; $display("FAIL nack_axis3 got=%h exp=ee", resp); end
    tick();
    total++;
    if ({d_axis, thrst, motors_off} !== {12'h801, 12'h800, 12'h7FF, 9'h1FE, 1'b1}) begin
      bad++; $display("FAIL nack_unchanged got=%h exp=%h", {d_axis, thrst, motors_off},
                      {12'h801, 12'h800, 12'h7FF, 9'h1FE, 1'b1});
    end
  endtask

  task automatic test_cal();
    int cyc;
    logic seen_clr;
    drive(8'h06, 16'h0000);
    total++;
    if ({inertial_cal, motors_off, clr_cmd_rdy, send_resp} !== 4'b1010) begin
      bad++; $display("FAIL cal_accept got=%b exp=1010", {inertial_cal, motors_off, clr_cmd_rdy, send_resp});
    end
    cmd = 8'h05; data = 16'h0077; cmd_rdy = 1'b1;
    cyc = 1;
    seen_clr = 1'b0;
    while (!strt_cal && cyc < 40) begin
      tick();
      cyc++;
      if (clr_cmd_rdy) seen_clr = 1'b1;
    end
    total++;
    if (cyc !== 16) begin bad++; $display("FAIL cal_strt_latency got=%0d exp=16", cyc); end
    total++;
    if ({seen_clr, thrst} !== {1'b0, 9'h1FE}) begin bad++; $display("FAIL cal_cmd_held got=%h exp=%h", {seen_clr, thrst}, {1'b0, 9'h1FE}); end
    tick();
    total++;
    if ({strt_cal, inertial_cal} !== 2'b01) begin bad++; $display("FAIL cal_strt_pulse got=%b exp=01", {strt_cal, inertial_cal}); end
    tick();
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    total++;
    if ({send_resp, resp, inertial_cal, clr_cmd_rdy} !== {1'b1, 8'hA5, 2'b00}) begin
      bad++; $display("FAIL cal_done_resp got=%h exp=%h", {send_resp, resp, inertial_cal, clr_cmd_rdy}, {1'b1, 8'hA5, 2'b00});
    end
    tick();
    cmd_rdy = 1'b0;
    total++;
    if ({clr_cmd_rdy, send_resp, thrst} !== {2'b11, 9'h077}) begin
      bad++; $display("FAIL cal_held_thrst got=%h exp=%h", {clr_cmd_rdy, send_resp, thrst}, {2'b11, 9'h077});
    end
    tick();
  endtask

  task automatic test_wdog();
    drive(8'h10, 16'h0100); tick();
    repeat (62) tick();
    total++;
    if ({wdog_trip, d_axis[11:0]} !== {1'b0, 12'h100}) begin bad++; $display("FAIL wdog_early got=%h exp=0100", {wdog_trip, d_axis[11:0]}); end
    tick();
    total++;
    if (wdog_trip !== 1'b0) begin bad++; $display("FAIL wdog_expiry_cycle got=%b exp=0", wdog_trip); end
    tick();
    total++;
    if ({wdog_trip, send_resp, d_axis, thrst} !== {2'b10, 45'h0}) begin
      bad++; $display("FAIL wdog_trip got=%h exp=%h", {wdog_trip, send_resp, d_axis, thrst}, {2'b10, 45'h0});
    end
  endtask

  task automatic test_wdog_race();
    drive(8'h11, 16'h0055);
    total++;
    if (wdog_trip !== 1'b0) begin bad++; $display("FAIL wdog_trip_clear got=%b exp=0", wdog_trip); end
    tick();
    repeat (63) tick();
    cmd = 8'h12; data = 16'h0066; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    total++;
    if ({clr_cmd_rdy, send_resp, resp, wdog_trip} !== {2'b11, 8'hA5, 1'b0}) begin
      bad++; $display("FAIL wdog_race_ack got=%h exp=%h", {clr_cmd_rdy, send_resp, resp, wdog_trip}, {2'b11, 8'hA5, 1'b0});
    end
    total++;
    if (d_axis !== {12'h066, 12'h055, 12'h000}) begin bad++; $display("FAIL wdog_race_axes got=%h exp=066055000", d_axis); end
    tick();
  endtask

  task automatic test_emer_mtrs();
    drive(8'h05, 16'h0010); tick();
    total++;
    if (thrst !== 9'h010) begin bad++; $display("FAIL emer_pre_thrst got=%h exp=010", thrst); end
    drive(8'h07, 16'h0000); tick();
    total++;
    if ({d_axis, thrst, motors_off} !== 46'h0) begin bad++; $display("FAIL emer_land got=%h exp=0", {d_axis, thrst, motors_off}); end
    drive(8'h08, 16'h0000); tick();
    total++;
    if (motors_off !== 1'b1) begin bad++; $display("FAIL mtrs_off got=%b exp=1", motors_off); end
    drive(8'h10, 16'h0200); tick();
    repeat (80) tick();
    total++;
    if ({wdog_trip, d_axis[11:0]} !== {1'b0, 12'h200}) begin bad++; $display("FAIL wdog_motors_off got=%h exp=0200", {wdog_trip, d_axis[11:0]}); end
  endtask

  task automatic test_reset_ramp();
    logic seen;
    drive(8'h05, 16'h0033); tick();
    drive(8'h06, 16'h0000);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({d_axis, thrst, motors_off, inertial_cal, send_resp, clr_cmd_rdy, strt_cal} !== {45'h0, 5'b10000}) begin
      bad++; $display("FAIL reset_ramp_vals got=%h exp=%h",
                      {d_axis, thrst, motors_off, inertial_cal, send_resp, clr_cmd_rdy, strt_cal}, {45'h0, 5'b10000});
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (strt_cal || send_resp) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_ramp_aborted got=%b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_wide();
    test_legacy();
    test_saturation();
    test_nack();
    test_cal();
    test_wdog();
    test_wdog_race();
    test_emer_mtrs();
    test_reset_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
